phoenix_dl_ctrl: RTL and testbench

ROM download sequencer for the Phoenix core. Sits between the HPS ioctl download port and the core's ROM/PROM write ports. Decodes each download byte into one of five ROM regions, validates the image size, and sequences the core reset so the game only runs on a complete image. Replaces the ad-hoc `reset | download` OR at top level with a state-machined reset controller that also absorbs menu/button reset requests.

---
 rtl/phoenix_dl_ctrl.sv | 155 +++++++++++++++
 tb/tb_phoenix_dl_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/phoenix_dl_ctrl.sv
// ROM download sequencer for the Phoenix core: decodes ioctl bytes into ROM/PROM
// write strobes, validates the image size and sequences the core reset.
module phoenix_dl_ctrl #(
    parameter int unsigned RESET_HOLD = 16,
    parameter logic [15:0] IMAGE_SIZE = 16'h6200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    input  logic        soft_reset,
    output logic [13:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        wr_prog,
    output logic        wr_char_fg,
    output logic        wr_char_bg,
    output logic        wr_prom_lo,
    output logic        wr_prom_hi,
    output logic        core_reset,
    output logic        rom_ready,
    output logic        err_size,
    output logic        err_overflow
);

    typedef enum logic [1:0] {StEmpty, StLoading, StHold, StRun} state_e;

    localparam logic [15:0] HoldLoad = 16'(RESET_HOLD - 1);

    state_e      state_q, state_d;
    logic        dl_wr_q;
    logic [14:0] count_q, count_d;
    logic [15:0] hold_q, hold_d;
    logic        err_size_q, err_size_d;
    logic        err_overflow_q, err_overflow_d;
    logic [13:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [4:0]  strobe_q, strobe_d;  // {prom_hi, prom_lo, char_bg, char_fg, prog}
    logic        core_reset_q, rom_ready_q;
    logic        accept, overflow;

    assign accept   = dl_active & dl_wr & ~dl_wr_q;
    assign overflow = (dl_addr[24:15] != '0) || (dl_addr[14:0] >= 15'h6200);

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        hold_d         = hold_q;
        err_size_d     = err_size_q;
        err_overflow_d = err_overflow_q;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        strobe_d       = '0;

        unique case (state_q)
            StEmpty: ;
            StLoading: begin
                if (!dl_active) begin
                    if ({1'b0, count_q} == IMAGE_SIZE) begin
                        state_d = StHold;
                        hold_d  = HoldLoad;
                    end else begin
                        state_d    = StEmpty;
                        err_size_d = 1'b1;
                    end
                end
            end
            StHold: begin
                if (soft_reset) begin
                    hold_d = HoldLoad;
                end else if (hold_q == '0) begin
                    state_d = StRun;
                end else begin
                    hold_d = hold_q - 16'd1;
                end
            end
            StRun: begin
                if (soft_reset) begin
                    state_d = StHold;
                    hold_d  = HoldLoad;
                end
            end
            default: state_d = StEmpty;
        endcase

        // A new download overrides every state; entering LOADING starts a fresh image.
        if (dl_active) begin
            state_d = StLoading;
            if (state_q != StLoading) begin
                count_d        = '0;
                err_size_d     = 1'b0;
                err_overflow_d = 1'b0;
            end
        end

        if (accept) begin
            if (overflow) begin
                err_overflow_d = 1'b1;
            end else begin
                if (count_d != 15'h7FFF) count_d = count_d + 15'd1;
                wr_data_d = dl_data;
                unique casez (dl_addr[14:8])
                    7'b0??_????: begin strobe_d[0] = 1'b1; wr_addr_d = dl_addr[13:0];          end
                    7'b100_????: begin strobe_d[1] = 1'b1; wr_addr_d = {2'b00, dl_addr[11:0]}; end
                    7'b101_????: begin strobe_d[2] = 1'b1; wr_addr_d = {2'b00, dl_addr[11:0]}; end
                    7'b110_0000: begin strobe_d[3] = 1'b1; wr_addr_d = {6'd0, dl_addr[7:0]};   end
                    7'b110_0001: begin strobe_d[4] = 1'b1; wr_addr_d = {6'd0, dl_addr[7:0]};   end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StEmpty;
            dl_wr_q        <= 1'b0;
            count_q        <= '0;
            hold_q         <= '0;
            err_size_q     <= 1'b0;
            err_overflow_q <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            strobe_q       <= '0;
            core_reset_q   <= 1'b1;
            rom_ready_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            dl_wr_q        <= dl_wr;
            count_q        <= count_d;
            hold_q         <= hold_d;
            err_size_q     <= err_size_d;
            err_overflow_q <= err_overflow_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            strobe_q       <= strobe_d;
            core_reset_q   <= (state_d != StRun);
            rom_ready_q    <= (state_d == StHold) || (state_d == StRun);
        end
    end

    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign wr_prog      = strobe_q[0];
    assign wr_char_fg   = strobe_q[1];
    assign wr_char_bg   = strobe_q[2];
    assign wr_prom_lo   = strobe_q[3];
    assign wr_prom_hi   = strobe_q[4];
    assign core_reset   = core_reset_q;
    assign rom_ready    = rom_ready_q;
    assign err_size     = err_size_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_phoenix_dl_ctrl.sv
// Bench for phoenix_dl_ctrl: strobe scoreboard plus reset-sequencing scenarios.
// A reduced image size keeps runtime short while still touching every region.
module tb_phoenix_dl_ctrl;

    localparam int unsigned HOLD = 16;
    localparam int          IMG  = 584;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        dl_active = 1'b0, dl_wr = 1'b0, soft_reset = 1'b0;
    logic [24:0] dl_addr = '0;
    logic [7:0]  dl_data = '0;
    logic [13:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_prog, wr_char_fg, wr_char_bg, wr_prom_lo, wr_prom_hi;
    logic        core_reset, rom_ready, err_size, err_overflow;

    phoenix_dl_ctrl #(.RESET_HOLD(HOLD), .IMAGE_SIZE(16'(IMG))) dut (
        .clk(clk), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .soft_reset(soft_reset),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_prog(wr_prog),
        .wr_char_fg(wr_char_fg), .wr_char_bg(wr_char_bg), .wr_prom_lo(wr_prom_lo),
        .wr_prom_hi(wr_prom_hi), .core_reset(core_reset), .rom_ready(rom_ready),
        .err_size(err_size), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  strb;
        logic [13:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [4:0]  mon_s;
    int          n_checks = 0, n_fail = 0;
    int          got_cnt[5], exp_cnt[5];
    logic [24:0] bound_tab[11];

    function automatic wr_t model(input logic [24:0] a, input logic [7:0] d);
        wr_t r;
        r.data = d; r.strb = '0; r.addr = '0;
        if (a < 25'h4000)      begin r.strb = 5'b00001; r.addr = 14'(a);            end
        else if (a < 25'h5000) begin r.strb = 5'b00010; r.addr = 14'(a - 25'h4000); end
        else if (a < 25'h6000) begin r.strb = 5'b00100; r.addr = 14'(a - 25'h5000); end
        else if (a < 25'h6100) begin r.strb = 5'b01000; r.addr = 14'(a - 25'h6000); end
        else if (a < 25'h6200) begin r.strb = 5'b10000; r.addr = 14'(a - 25'h6100); end
        return r;
    endfunction

    function automatic logic [24:0] img_addr(input int i);
        return (i < 11) ? bound_tab[i] : 25'(i * 43);
    endfunction

    // Scoreboard: every strobe seen must match the oldest expected write.
    always @(negedge clk) begin
        mon_s = {wr_prom_hi, wr_prom_lo, wr_char_bg, wr_char_fg, wr_prog};
        if (mon_s != 5'd0) begin
            for (int k = 0; k < 5; k++) if (mon_s[k]) got_cnt[k]++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: got strb=%b addr=%h data=%h, expected none",
                         mon_s, wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({mon_s, wr_addr, wr_data} !== mon_e) begin
                    n_fail++;
                    $display("FAIL strobe_write: got strb=%b addr=%h data=%h, expected %b %h %h",
                             mon_s, wr_addr, wr_data, mon_e.strb, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 5; k++) begin got_cnt[k] = 0; exp_cnt[k] = 0; end
    endtask

    // tight: the byte's write is accepted in the final dl_active=1 cycle.
    task automatic send_byte(input logic [24:0] a, input int hold, input bit tight);
        logic [7:0] d;
        wr_t        e;
        d = 8'($urandom);
        e = model(a, d);
        if (e.strb != 5'd0) begin
            exp_q.push_back(e);
            for (int k = 0; k < 5; k++) if (e.strb[k]) exp_cnt[k]++;
        end
        dl_addr = a; dl_data = d; dl_wr = 1'b1;
        step(hold);
        dl_wr = 1'b0;
        if (tight) dl_active = 1'b0;
        else step(3);
    endtask

    task automatic download(input int nbytes, input bit ovf, input int hold, input bit tight);
        dl_active = 1'b1;
        step(2);
        for (int i = 0; i < nbytes; i++) begin
            if (ovf && i == nbytes / 2) begin
                send_byte(25'h6200, hold, 1'b0);
                send_byte(25'h1_0000, hold, 1'b0);
            end
            send_byte(img_addr(i), hold, tight && (i == nbytes - 1));
        end
        dl_active = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        n_checks++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL rst_core_reset: got %b expected 1", core_reset); end
        n_checks++; if (rom_ready !== 1'b0) begin n_fail++; $display("FAIL rst_rom_ready: got %b expected 0", rom_ready); end
        n_checks++; if (err_size !== 1'b0) begin n_fail++; $display("FAIL rst_err_size: got %b expected 0", err_size); end
        n_checks++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_err_ovf: got %b expected 0", err_overflow); end
        n_checks++;
        if ({wr_prog, wr_char_fg, wr_char_bg, wr_prom_lo, wr_prom_hi} !== 5'd0) begin
            n_fail++; $display("FAIL rst_strobes: got %b expected 0",
                               {wr_prog, wr_char_fg, wr_char_bg, wr_prom_lo, wr_prom_hi});
        end
        n_checks++; if (wr_addr !== 14'd0) begin n_fail++; $display("FAIL rst_wr_addr: got %h expected 0", wr_addr); end
        n_checks++; if (wr_data !== 8'd0) begin n_fail++; $display("FAIL rst_wr_data: got %h expected 0", wr_data); end
        step(1);
        reset = 1'b0;
        step(4);
        n_checks++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL empty_core_reset: got %b expected 1", core_reset); end
    endtask

    task automatic test_full_image();
        clear_counts();
        download(IMG, 1'b0, 1, 1'b1);
        step(1);
        n_checks++; if (rom_ready !== 1'b1) begin n_fail++; $display("FAIL full_rom_ready: got %b expected 1", rom_ready); end
        n_checks++; if (err_size !== 1'b0) begin n_fail++; $display("FAIL full_err_size: got %b expected 0", err_size); end
        n_checks++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL full_err_ovf: got %b expected 0", err_overflow); end
        step(HOLD - 1);
        n_checks++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL full_hold_early: got %b expected 1", core_reset); end
        step(1);
        n_checks++; if (core_reset !== 1'b0) begin n_fail++; $display("FAIL full_hold_release: got %b expected 0", core_reset); end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (got_cnt[k] !== exp_cnt[k]) begin
                n_fail++; $display("FAIL full_region_count[%0d]: got %0d expected %0d", k, got_cnt[k], exp_cnt[k]);
            end
        end
    endtask

    task automatic test_short_image();
        int bad;
        dl_active = 1'b1;
        step(1);
        n_checks++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL restart_core_reset: got %b expected 1", core_reset); end
        n_checks++; if (rom_ready !== 1'b0) begin n_fail++; $display("FAIL restart_rom_ready: got %b expected 0", rom_ready); end
        download(IMG - 1, 1'b0, 1, 1'b0);
        step(1);
        n_checks++; if (err_size !== 1'b1) begin n_fail++; $display("FAIL short_err_size: got %b expected 1", err_size); end
        n_checks++; if (rom_ready !== 1'b0) begin n_fail++; $display("FAIL short_rom_ready: got %b expected 0", rom_ready); end
        soft_reset = 1'b1;
        step(3);
        soft_reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (core_reset !== 1'b1 || rom_ready !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL short_stays_reset: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_overflow();
        download(IMG, 1'b1, 1, 1'b0);
        step(1);
        n_checks++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_err_ovf: got %b expected 1", err_overflow); end
        n_checks++; if (err_size !== 1'b0) begin n_fail++; $display("FAIL ovf_err_size: got %b expected 0", err_size); end
        n_checks++; if (rom_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_rom_ready: got %b expected 1", rom_ready); end
        step(HOLD);
        n_checks++; if (core_reset !== 1'b0) begin n_fail++; $display("FAIL ovf_run: got %b expected 0", core_reset); end
    endtask

    task automatic test_soft_reset();
        soft_reset = 1'b1;
        step(1);
        n_checks++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL soft_assert: got %b expected 1", core_reset); end
        step(4);
        soft_reset = 1'b0;
        step(HOLD - 1);
        n_checks++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL soft_hold_early: got %b expected 1", core_reset); end
        n_checks++; if (rom_ready !== 1'b1) begin n_fail++; $display("FAIL soft_rom_ready: got %b expected 1", rom_ready); end
        step(1);
        n_checks++; if (core_reset !== 1'b0) begin n_fail++; $display("FAIL soft_release: got %b expected 0", core_reset); end
    endtask

    task automatic test_async_reset();
        dl_active = 1'b1;
        step(2);
        send_byte(25'h100_0000, 1, 1'b0);
        n_checks++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL bit24_err_ovf: got %b expected 1", err_overflow); end
        dl_addr = 25'h1234; dl_data = 8'hA5; dl_wr = 1'b1;
        step(1);
        n_checks++;
        if (wr_prog !== 1'b1 || wr_addr !== 14'h1234) begin
            n_fail++; $display("FAIL pending_strobe: got prog=%b addr=%h expected 1 1234", wr_prog, wr_addr);
        end
        #2 reset = 1'b1; dl_wr = 1'b0; dl_active = 1'b0;
        #1;
        n_checks++;
        if ({wr_prog, wr_char_fg, wr_char_bg, wr_prom_lo, wr_prom_hi} !== 5'd0) begin
            n_fail++; $display("FAIL async_strobes: got %b expected 0",
                               {wr_prog, wr_char_fg, wr_char_bg, wr_prom_lo, wr_prom_hi});
        end
        n_checks++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL async_err_ovf: got %b expected 0", err_overflow); end
        n_checks++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL async_core_reset: got %b expected 1", core_reset); end
        n_checks++; if (wr_addr !== 14'd0 || wr_data !== 8'd0) begin n_fail++; $display("FAIL async_wr_bus: got %h/%h expected 0/0", wr_addr, wr_data); end
        step(1);
        reset = 1'b0;
        step(3);
        n_checks++; if (err_size !== 1'b0) begin n_fail++; $display("FAIL async_empty_err_size: got %b expected 0", err_size); end
        n_checks++; if (rom_ready !== 1'b0) begin n_fail++; $display("FAIL async_empty_rom_ready: got %b expected 0", rom_ready); end
    endtask

    // Each byte holds dl_wr for 3 cycles; soft_reset is asserted throughout and must
    // not disturb LOADING, then keeps HOLD reloading until it drops.
    task automatic test_held_wr();
        int total;
        clear_counts();
        soft_reset = 1'b1;
        download(IMG, 1'b0, 3, 1'b0);
        step(10);
        n_checks++; if (rom_ready !== 1'b1) begin n_fail++; $display("FAIL held_rom_ready: got %b expected 1", rom_ready); end
        n_checks++; if (err_size !== 1'b0) begin n_fail++; $display("FAIL held_err_size: got %b expected 0", err_size); end
        n_checks++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL held_soft_hold: got %b expected 1", core_reset); end
        soft_reset = 1'b0;
        step(HOLD - 1);
        n_checks++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL held_hold_early: got %b expected 1", core_reset); end
        step(1);
        n_checks++; if (core_reset !== 1'b0) begin n_fail++; $display("FAIL held_release: got %b expected 0", core_reset); end
        total = 0;
        for (int k = 0; k < 5; k++) total += got_cnt[k];
        n_checks++; if (total != IMG) begin n_fail++; $display("FAIL held_strobe_total: got %0d expected %0d", total, IMG); end
    endtask

    initial begin
        bound_tab = '{25'h0000, 25'h3FFF, 25'h4000, 25'h4FFF, 25'h5000, 25'h5123,
                      25'h5FFF, 25'h6000, 25'h60FF, 25'h6100, 25'h61FF};
        clear_counts();
        test_reset();
        test_full_image();
        test_short_image();
        test_overflow();
        test_soft_reset();
        test_async_reset();
        test_held_wr();
        step(2);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d pending writes expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
